// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the RV32 instruction field [31:7] for a selected format,
// flagging unrepresentable values. Two-stage valid/ready pipeline with saturating error count.
module imm_encoder #(
  parameter int unsigned IMM_WIDTH = 25,
  parameter int unsigned IN_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_imm_type,
  input  logic [IN_WIDTH-1:0]  i_value,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [IMM_WIDTH-1:0] o_imm,
  output logic [2:0]           o_type,
  output logic                 o_range_err,
  output logic [7:0]           o_err_count
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [TYPE_W-1:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_CSR = 3'd5
  } fmt_e;

  // Codes 110/111 fall back to the I format.
  function automatic fmt_e decode(input logic [TYPE_W-1:0] t);
    case (t)
      3'd1:    return FMT_S;
      3'd2:    return FMT_B;
      3'd3:    return FMT_J;
      3'd4:    return FMT_U;
      3'd5:    return FMT_CSR;
      default: return FMT_I;
    endcase
  endfunction

  function automatic logic range_err(input fmt_e f, input logic [IN_WIDTH-1:0] v);
    case (f)
      FMT_B:   return !(&v[31:12] || ~|v[31:12]) || v[0];
      FMT_J:   return !(&v[31:20] || ~|v[31:20]) || v[0];
      FMT_U:   return |v[11:0];
      FMT_CSR: return |v[31:5];
      default: return !(&v[31:11] || ~|v[31:11]);
    endcase
  endfunction

  // Field bit k maps to instruction bit k+7; unlisted bits stay zero.
  function automatic logic [IMM_WIDTH-1:0] pack(input fmt_e f, input logic [IN_WIDTH-1:0] v);
    logic [IMM_WIDTH-1:0] imm;
    imm = '0;
    case (f)
      FMT_S: begin
        imm[24:18] = v[11:5];
        imm[4:0]   = v[4:0];
      end
      FMT_B: begin
        imm[24]    = v[12];
        imm[23:18] = v[10:5];
        imm[4:1]   = v[4:1];
        imm[0]     = v[11];
      end
      FMT_J: begin
        imm[24]    = v[20];
        imm[23:14] = v[10:1];
        imm[13]    = v[11];
        imm[12:5]  = v[19:12];
      end
      FMT_U:   imm[24:5]  = v[31:12];
      FMT_CSR: imm[12:8]  = v[4:0];
      default: imm[24:13] = v[11:0];
    endcase
    return imm;
  endfunction

  logic                s1_valid;
  logic [TYPE_W-1:0]   s1_type;
  logic [IN_WIDTH-1:0] s1_value;
  logic                s1_err;
  logic                s1_adv;
  logic                s2_adv;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;

  // Stage 1: capture the transaction and its range check.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_type  <= '0;
      s1_value <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_type  <= i_imm_type;
        s1_value <= i_value;
        s1_err   <= range_err(decode(i_imm_type), i_value);
      end
    end
  end

  // Stage 2: packed output, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_imm       <= '0;
      o_type      <= '0;
      o_range_err <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_imm       <= pack(decode(s1_type), s1_value);
        o_type      <= s1_type;
        o_range_err <= s1_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_err_count <= '0;
    end else if (o_valid && i_ready && o_range_err && (o_err_count != '1)) begin
      o_err_count <= o_err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized self-checking bench for imm_encoder: scoreboard of expected transactions built
// from instruction-format layouts and numeric range rules, plus a cycle-level timing model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_imm_type;
  logic [31:0] i_value;
  logic        o_valid;
  logic        i_ready;
  logic [24:0] o_imm;
  logic [2:0]  o_type;
  logic        o_range_err;
  logic [7:0]  o_err_count;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_imm_type  (i_imm_type),
    .i_value     (i_value),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_imm       (o_imm),
    .o_type      (o_type),
    .o_range_err (o_range_err),
    .o_err_count (o_err_count)
  );

  typedef struct {
    logic [24:0] imm;
    logic [2:0]  t;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   now      = 0;
  int   last_del = -10;
  int   err_m    = 0;
  int   n_del    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  // Build the instruction word as the ISA lays out each immediate, then take bits [31:7].
  function automatic logic [24:0] ref_pack(input logic [2:0] t, input logic [31:0] v);
    logic [31:7] ins;
    ins = '0;
    case (t)
      3'd1: begin ins[31:25] = v[11:5]; ins[11:7] = v[4:0]; end
      3'd2: begin ins[31] = v[12]; ins[30:25] = v[10:5]; ins[11:8] = v[4:1]; ins[7] = v[11]; end
      3'd3: begin ins[31] = v[20]; ins[30:21] = v[10:1]; ins[20] = v[11]; ins[19:12] = v[19:12]; end
      3'd4: ins[31:12] = v[31:12];
      3'd5: ins[19:15] = v[4:0];
      default: ins[31:20] = v[11:0];
    endcase
    return ins;
  endfunction

  function automatic logic ref_err(input logic [2:0] t, input logic [31:0] v);
    int s;
    s = $signed(v);
    case (t)
      3'd2: return (s < -4096) || (s > 4095) || v[0];
      3'd3: return (s < -1048576) || (s > 1048575) || v[0];
      3'd4: return (v % 32'd4096) != 32'd0;
      3'd5: return v > 32'd31;
      default: return (s < -2048) || (s > 2047);
    endcase
  endfunction

  function automatic logic [31:0] gen_value();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return 32'($urandom_range(0, 4194303)) - 32'h0020_0000;
      3: return $urandom & 32'hFFFF_F000;
      default: return 32'($urandom_range(0, 63));
    endcase
  endfunction

  // One clock: drive at the falling edge, check against the model, account for handshakes.
  task automatic cycle(input logic v, input logic [2:0] t, input logic [31:0] val,
                       input logic rdy, output logic acc);
    logic exp_ov;
    logic del;
    int   due;
    exp_t e;
    @(negedge clk);
    now++;
    i_valid = v; i_imm_type = t; i_value = val; i_ready = rdy;
    #1;
    exp_ov = 1'b0;
    if (q.size() > 0) begin
      due = q[0].acc + 2;
      if (last_del + 1 > due) due = last_del + 1;
      exp_ov = (now >= due);
    end
    check("o_ready", 32'(o_ready), 32'((q.size() < 2) || rdy));
    check("o_valid", 32'(o_valid), 32'(exp_ov));
    check("o_err_count", 32'(o_err_count), 32'(err_m));
    if (o_valid && q.size() > 0) begin
      check("o_imm", 32'(o_imm), 32'(q[0].imm));
      check("o_type", 32'(o_type), 32'(q[0].t));
      check("o_range_err", 32'(o_range_err), 32'(q[0].err));
    end
    del = o_valid && rdy && (q.size() > 0);
    if (del) begin
      if (q[0].err && err_m < 255) err_m++;
      void'(q.pop_front());
      last_del = now;
      n_del++;
    end
    acc = v && o_ready;
    if (acc) begin
      e.imm = ref_pack(t, val);
      e.t   = t;
      e.err = ref_err(t, val);
      e.acc = now;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] val);
    logic acc;
    int   k;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      cycle(1'b1, t, val, 1'b1, acc);
      k++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   k;
    k = 0;
    while (q.size() > 0 && k < 100) begin
      cycle(1'b0, 3'd0, 32'd0, 1'b1, acc);
      k++;
    end
    cycle(1'b0, 3'd0, 32'd0, 1'b1, acc);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    now++;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_imm_type = 3'd0; i_value = 32'd0;
    @(negedge clk);
    now++;
    i_rst = 1'b0;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_imm", 32'(o_imm), 32'd0);
    check("rst_o_type", 32'(o_type), 32'd0);
    check("rst_o_range_err", 32'(o_range_err), 32'd0);
    check("rst_o_err_count", 32'(o_err_count), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    q.delete();
    err_m = 0;
    last_del = -10;
  endtask

  logic [2:0]  d_t [12] = '{3'd0, 3'd2, 3'd2, 3'd4, 3'd4, 3'd3, 3'd5, 3'd5, 3'd1, 3'd6, 3'd7, 3'd3};
  logic [31:0] d_v [12] = '{32'hFFFF_F800, 32'h0000_0FFE, 32'h0000_0FFF, 32'h1234_5000,
                            32'h1234_5001, 32'h0010_0000, 32'h0000_001F, 32'h0000_0020,
                            32'hFFFF_F7FF, 32'h0000_07FF, 32'h0000_0800, 32'h000F_FFFE};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic pend;
    logic saw_low;
    logic [2:0]  pt;
    logic [31:0] pv;
    int k;
    int j;
    int del0;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_imm_type = 3'd0; i_value = 32'd0;
    do_reset();

    for (int i = 0; i < 12; i++) send(d_t[i], d_v[i]);
    drain();

    // Backpressure: ten values streamed with the consumer stalled for three cycles.
    del0 = n_del;
    saw_low = 1'b0;
    k = 0;
    j = 0;
    while (k < 10 && j < 100) begin
      cycle(1'b1, 3'(k % 6), 32'(k * 37) - 32'd150, !(j >= 4 && j < 7), acc);
      if (!o_ready) saw_low = 1'b1;
      if (acc) k++;
      j++;
    end
    drain();
    check("bp_ready_fell", 32'(saw_low), 32'd1);
    check("bp_delivered", 32'(n_del - del0), 32'd10);

    pend = 1'b0;
    pt = 3'd0;
    pv = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pt = 3'($urandom_range(0, 7));
        pv = gen_value();
      end
      cycle(pend, pt, pv, $urandom_range(0, 3) != 0, acc);
      if (acc) pend = 1'b0;
    end
    drain();

    for (int i = 0; i < 300; i++) send(3'd4, 32'd1);
    drain();
    check("err_saturated", 32'(o_err_count), 32'd255);

    // Flush two in-flight transactions with a mid-stream reset.
    cycle(1'b1, 3'd0, 32'd5, 1'b0, acc);
    cycle(1'b1, 3'd4, 32'd3, 1'b0, acc);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 32'd0, 1'b1, acc);
    send(3'd5, 32'h1F);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
